// File: rtl/pipeline_sink_endpoint_pkg.sv
// Shared definitions for the clocked sink endpoint: FSM state encodings and default widths.
package pipeline_sink_endpoint_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_EREQ = 2'd2,
        ST_EREL = 2'd3
    } state_t;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int ERR_CNT_W       = 8;

endpackage

// File: rtl/pipeline_sink_endpoint_sync_fifo.sv
// Show-ahead synchronous FIFO; full/empty come from registered wrap-bit pointers.
module pipeline_sink_endpoint_sync_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Full is judged on the pointers as they stand, so a same-cycle pop cannot admit a push.
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/pipeline_sink_endpoint.sv
// Clocked right-hand terminator: 4-phase data/error handshakes in, parity check, FIFO out.
module pipeline_sink_endpoint
    import pipeline_sink_endpoint_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 Lreq,
    input  logic [DATA_W:0]      Ldata,
    output logic                 Lack,
    output logic                 LEreq,
    input  logic                 LEack,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 busy
);

    function automatic logic parity_ok(input logic [DATA_W:0] v);
        return ~^v;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic req_s;
    logic eack_s;

    for (genvar i = 0; i < SYNC_STAGES; i++) begin : g_sync
        logic req_in;
        logic eack_in;
        logic req_p;
        logic eack_p;
        if (i == 0) begin : g_first
            assign req_in  = Lreq;
            assign eack_in = LEack;
        end else begin : g_chain
            assign req_in  = g_sync[i-1].req_p;
            assign eack_in = g_sync[i-1].eack_p;
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                req_p  <= 1'b0;
                eack_p <= 1'b0;
            end else begin
                req_p  <= req_in;
                eack_p <= eack_in;
            end
        end
    end

    assign req_s  = g_sync[SYNC_STAGES-1].req_p;
    assign eack_s = g_sync[SYNC_STAGES-1].eack_p;

    state_t                state_q;
    state_t                state_d;
    logic                  push;
    logic                  err_inc;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  lack_q;
    logic                  lereq_q;
    logic [ERR_CNT_W-1:0]  err_q;

    // Ldata is bundled with Lreq, so it is already stable once req_s is seen high.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        err_inc = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    if (!parity_ok(Ldata)) begin
                        err_inc = 1'b1;
                        state_d = ST_EREQ;
                    end else if (!fifo_full) begin
                        push    = 1'b1;
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK:  if (!req_s) state_d = ST_IDLE;
            ST_EREQ: if (eack_s) state_d = ST_EREL;
            ST_EREL: if (!eack_s) state_d = ST_ACK;
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are flopped from the next state so they never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lack_q  <= 1'b0;
            lereq_q <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            lack_q  <= (state_d == ST_ACK);
            lereq_q <= (state_d == ST_EREQ);
            if (err_inc) err_q <= sat_inc(err_q);
        end
    end

    pipeline_sink_endpoint_sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (Ldata[DATA_W-1:0]),
        .pop       (out_ready),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (out_data)
    );

    assign Lack      = lack_q;
    assign LEreq     = lereq_q;
    assign out_valid = !fifo_empty;
    assign err_count = err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pipeline_sink_endpoint.sv
// Bench for pipeline_sink_endpoint: acts as the upstream 4-phase controller and the consumer.
module tb_pipeline_sink_endpoint;

    localparam int DATA_W      = 8;
    localparam int SYNC_STAGES = 2;
    localparam int FIFO_DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              Lreq;
    logic [DATA_W:0]   Ldata;
    logic              Lack;
    logic              LEreq;
    logic              LEack;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        err_count;
    logic              busy;

    int vectors     = 0;
    int miscompares = 0;
    int bad_n       = 0;
    bit rand_ready  = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    pipeline_sink_endpoint #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES),
        .FIFO_DEPTH  (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Lreq      (Lreq),
        .Ldata     (Ldata),
        .Lack      (Lack),
        .LEreq     (LEreq),
        .LEack     (LEack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_count (err_count),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Consumer side: a pop happens on the next posedge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back(out_data);
        chk("lack_lereq_exclusive", 32'(Lack & LEreq), 32'd0);
    end

    function automatic logic [8:0] mk(input logic [7:0] p, input bit good);
        return {(good ? ^p : ~^p), p};
    endfunction

    function automatic int exp_err();
        return (bad_n > 255) ? 255 : bad_n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_for(input string tag, input bit use_lereq, input logic val, input int budget);
        int n = 0;
        while (((use_lereq ? LEreq : Lack) !== val) && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(use_lereq ? LEreq : Lack), 32'(val));
    endtask

    task automatic send(input logic [8:0] d);
        bit good;
        good  = ~^d;
        Ldata = d;
        Lreq  = 1'b1;
        if (good) begin
            wait_for("ack_rise", 1'b0, 1'b1, 300);
            exp_q.push_back(d[7:0]);
        end else begin
            wait_for("lereq_rise", 1'b1, 1'b1, 50);
            chk("lack_low_in_err", 32'(Lack), 32'd0);
            LEack = 1'b1;
            wait_for("lereq_fall", 1'b1, 1'b0, 50);
            LEack = 1'b0;
            wait_for("err_ack_rise", 1'b0, 1'b1, 50);
            bad_n++;
        end
        Lreq = 1'b0;
        wait_for("ack_fall", 1'b0, 1'b0, 50);
    endtask

    task automatic drain_and_compare(input string tag);
        int n = 0;
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        while (out_valid !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        chk({tag, "_empty"}, 32'(out_valid), 32'd0);
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_data"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        rst       = 1'b1;
        Lreq      = 1'b0;
        Ldata     = '0;
        LEack     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lack", 32'(Lack), 32'd0);
        chk("rst_lereq", 32'(LEreq), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // Reset in the middle of an acknowledged handshake.
        Ldata = mk(8'h3C, 1'b1);
        Lreq  = 1'b1;
        wait_for("midack_rise", 1'b0, 1'b1, 20);
        chk("midack_valid", 32'(out_valid), 32'd1);
        rst  = 1'b1;
        Lreq = 1'b0;
        #1;
        chk("midrst_lack", 32'(Lack), 32'd0);
        chk("midrst_lereq", 32'(LEreq), 32'd0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_err", 32'(err_count), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        got_q.delete();

        // Single good token with latency check.
        Ldata = 9'h0A5;
        Lreq  = 1'b1;
        tick();
        tick();
        chk("single_lat2", 32'(Lack), 32'd0);
        tick();
        chk("single_lat3", 32'(Lack), 32'd1);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'hA5);
        exp_q.push_back(8'hA5);
        Lreq = 1'b0;
        wait_for("single_fall", 1'b0, 1'b0, 20);
        drain_and_compare("single");

        // Parity error token.
        send(9'h001);
        chk("perr_err", 32'(err_count), 32'(exp_err()));
        chk("perr_valid", 32'(out_valid), 32'd0);

        // Fill the FIFO, then backpressure on the fifth token.
        for (int i = 1; i <= 4; i++) send(mk(8'(i), 1'b1));
        Ldata = mk(8'h05, 1'b1);
        Lreq  = 1'b1;
        repeat (12) tick();
        chk("full_hold", 32'(Lack), 32'd0);
        chk("full_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("full_no_same_cycle", 32'(Lack), 32'd0);
        tick();
        chk("full_unblock", 32'(Lack), 32'd1);
        exp_q.push_back(8'h05);
        Lreq = 1'b0;
        wait_for("full_fall", 1'b0, 1'b0, 20);
        drain_and_compare("full");

        // Streaming with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(mk(8'(i), 1'b1));
        drain_and_compare("stream");

        // Randomized tokens and consumer readiness.
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) send(mk(8'($urandom), ($urandom_range(0, 3) != 0)));
        drain_and_compare("random");
        chk("random_err", 32'(err_count), 32'(exp_err()));

        // Error counter saturation.
        for (int i = 0; i < 300; i++) send(mk(8'($urandom), 1'b0));
        chk("sat_err", 32'(err_count), 32'(exp_err()));
        chk("sat_valid", 32'(out_valid), 32'd0);
        chk("sat_busy", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
